// File: rtl/paddle_ctrl.sv
// paddle_ctrl: Breakout paddle motion controller.
//
// On every cycle where tick is high, the debounced button levels pick a direction. The paddle
// moves by SPEED_SLOW pixels per tick and is clamped to [0, SCREEN_W - PADDLE_W]. Reversing
// direction, releasing, or pressing both buttons drops it back to slow speed.
//
// Optional feature macro: PADDLE_ACCEL_EN
//   Defined:   after ACCEL_TICKS consecutive same-direction ticks, the step becomes SPEED_FAST.
//   Undefined: the step is always SPEED_SLOW, and the hold counter is not built.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tick      in   frame pulse; all registers hold when it is low
//   btn_l     in   debounced left button level, active-high
//   btn_r     in   debounced right button level, active-high
//   paddle_x  out  left edge of the paddle, 0..SCREEN_W-PADDLE_W
//   moving    out  paddle position changed on the last tick
//   dir_r     out  direction of the last applied move (1 = right)
//   at_left   out  registered paddle_x == 0
//   at_right  out  registered paddle_x == SCREEN_W-PADDLE_W
`timescale 1ns / 1ps

module paddle_ctrl #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned PADDLE_W    = 64,
    parameter int unsigned X_INIT      = 288,
    parameter int unsigned SPEED_SLOW  = 2,
    parameter int unsigned SPEED_FAST  = 6,
    parameter int unsigned ACCEL_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [9:0] paddle_x,
    output logic       moving,
    output logic       dir_r,
    output logic       at_left,
    output logic       at_right
);

    localparam int unsigned X_MAX = SCREEN_W - PADDLE_W;

    localparam logic        [9:0]  XMax10    = 10'(X_MAX);
    localparam logic signed [10:0] XMaxS     = 11'(X_MAX);
    localparam logic signed [10:0] StepSlowS = 11'(SPEED_SLOW);

    // Elaboration-time sanity checks on the configuration.
    if (SCREEN_W > 1024 || PADDLE_W >= SCREEN_W || X_INIT > X_MAX ||
        SPEED_FAST < SPEED_SLOW || ACCEL_TICKS == 0 || ACCEL_TICKS > 31) begin : g_bad_cfg
        $error("paddle_ctrl: invalid parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StMoveL, StMoveR} state_e;

    state_e      state_q, state_d;
    logic [9:0]  paddle_x_q, paddle_x_d;
    logic        moving_q, moving_d;
    logic        dir_r_q, dir_r_d;
    logic        at_left_q, at_left_d;
    logic        at_right_q, at_right_d;

`ifdef PADDLE_ACCEL_EN
    localparam logic        [4:0]  AccelTicks5 = 5'(ACCEL_TICKS);
    localparam logic signed [10:0] StepFastS   = 11'(SPEED_FAST);

    logic [4:0] hold_cnt_q, hold_cnt_d;
`endif

    logic               req_l, req_r;
    state_e             req_state;
    logic signed [10:0] step;
    logic signed [10:0] pos_sum;
    logic        [9:0]  pos_new;

    assign req_l     = btn_l & ~btn_r;
    assign req_r     = btn_r & ~btn_l;
    assign req_state = req_r ? StMoveR : StMoveL;

    always_comb begin
        state_d    = state_q;
        moving_d   = moving_q;
        dir_r_d    = dir_r_q;
        at_left_d  = at_left_q;
        at_right_d = at_right_q;
`ifdef PADDLE_ACCEL_EN
        hold_cnt_d = hold_cnt_q;
`endif
        step       = StepSlowS;
        pos_sum    = $signed({1'b0, paddle_x_q});
        pos_new    = paddle_x_q;

        if (tick) begin
            if (!req_l && !req_r) begin
                state_d  = StIdle;
                moving_d = 1'b0;
`ifdef PADDLE_ACCEL_EN
                hold_cnt_d = 5'd0;
`endif
            end else begin
                if (state_q == req_state) begin
`ifdef PADDLE_ACCEL_EN
                    // Speed decision uses the count from before this tick.
                    if (hold_cnt_q == AccelTicks5) begin
                        step = StepFastS;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 5'd1;
                    end
`endif
                end else begin
                    state_d = req_state;
`ifdef PADDLE_ACCEL_EN
                    hold_cnt_d = 5'd1;
`endif
                end

                pos_sum = req_r ? (pos_sum + step) : (pos_sum - step);

                if (pos_sum < 11'sd0) begin
                    pos_new = 10'd0;
                end else if (pos_sum > XMaxS) begin
                    pos_new = XMax10;
                end else begin
                    pos_new = pos_sum[9:0];
                end

                // Pushing against a wall advances state but does not count as a move.
                moving_d = (pos_new != paddle_x_q);
                if (moving_d) begin
                    dir_r_d = req_r;
                end
            end

            at_left_d  = (pos_new == 10'd0);
            at_right_d = (pos_new == XMax10);
        end

        paddle_x_d = pos_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            paddle_x_q <= 10'(X_INIT);
            moving_q   <= 1'b0;
            dir_r_q    <= 1'b0;
            at_left_q  <= 1'b0;
            at_right_q <= 1'b0;
`ifdef PADDLE_ACCEL_EN
            hold_cnt_q <= 5'd0;
`endif
        end else begin
            state_q    <= state_d;
            paddle_x_q <= paddle_x_d;
            moving_q   <= moving_d;
            dir_r_q    <= dir_r_d;
            at_left_q  <= at_left_d;
            at_right_q <= at_right_d;
`ifdef PADDLE_ACCEL_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign paddle_x = paddle_x_q;
    assign moving   = moving_q;
    assign dir_r    = dir_r_q;
    assign at_left  = at_left_q;
    assign at_right = at_right_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed self-checking bench for paddle_ctrl with default parameters.
// Expected positions are hand-computed; acceleration expectations depend on PADDLE_ACCEL_EN.
`timescale 1ns / 1ps

module tb_paddle_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [9:0] paddle_x;
    logic       moving;
    logic       dir_r;
    logic       at_left;
    logic       at_right;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    paddle_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btn_l    (btn_l),
        .btn_r    (btn_r),
        .paddle_x (paddle_x),
        .moving   (moving),
        .dir_r    (dir_r),
        .at_left  (at_left),
        .at_right (at_right)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One tick with the given button levels; returns on the following negedge.
    task automatic do_tick(input logic l, input logic r);
        @(negedge clk);
        btn_l = l;
        btn_r = r;
        tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
    endtask

    // n held ticks then one released tick, so the hold count never reaches acceleration.
    task automatic burst(input logic l, input logic r, input int n);
        repeat (n) do_tick(l, r);
        do_tick(1'b0, 1'b0);
    endtask

    task automatic check_pos(input string tag, input int x, input logic mv);
        check_val({tag, "_x"}, 32'(paddle_x), 32'(x));
        check_val({tag, "_moving"}, 32'(moving), 32'(mv));
    endtask

    initial begin
        // Reset values
        #12;
        check_val("rst_x", 32'(paddle_x), 32'd288);
        check_val("rst_moving", 32'(moving), 32'd0);
        check_val("rst_dir_r", 32'(dir_r), 32'd0);
        check_val("rst_at_left", 32'(at_left), 32'd0);
        check_val("rst_at_right", 32'(at_right), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acceleration / constant-speed run to the right
        repeat (16) do_tick(1'b0, 1'b1);
        check_pos("r16", 320, 1'b1);
        check_val("r16_dir_r", 32'(dir_r), 32'd1);
        do_tick(1'b0, 1'b1);
`ifdef PADDLE_ACCEL_EN
        check_pos("r17", 326, 1'b1);
`else
        check_pos("r17", 322, 1'b1);
`endif
        repeat (3) do_tick(1'b0, 1'b1);
`ifdef PADDLE_ACCEL_EN
        check_pos("r20", 344, 1'b1);
`else
        check_pos("r20", 328, 1'b1);
`endif

        // Reversal at speed: first left step is slow
        do_tick(1'b1, 1'b0);
`ifdef PADDLE_ACCEL_EN
        check_pos("rev", 342, 1'b1);
`else
        check_pos("rev", 326, 1'b1);
`endif
        check_val("rev_dir_r", 32'(dir_r), 32'd0);

        // Release, then both buttons: no motion
        do_tick(1'b0, 1'b0);
`ifdef PADDLE_ACCEL_EN
        check_pos("rel", 342, 1'b0);
`else
        check_pos("rel", 326, 1'b0);
`endif
        repeat (5) do_tick(1'b1, 1'b1);
`ifdef PADDLE_ACCEL_EN
        check_pos("both", 342, 1'b0);
        check_val("both_hold", 32'(dut.hold_cnt_q), 32'd0);
`else
        check_pos("both", 326, 1'b0);
`endif

        // btn_r toggling between ticks is invisible
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_r = ~btn_r;
        end
        btn_r = 1'b1;
        @(negedge clk);
        btn_r = 1'b0;
        do_tick(1'b0, 1'b0);
`ifdef PADDLE_ACCEL_EN
        check_pos("gate", 342, 1'b0);
`else
        check_pos("gate", 326, 1'b0);
`endif

        // Reset mid-motion at 400
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) burst(1'b0, 1'b1, 15);
        repeat (11) do_tick(1'b0, 1'b1);
        check_pos("pre_rst", 400, 1'b1);
        @(negedge clk);
        btn_r = 1'b1;
        tick  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_x", 32'(paddle_x), 32'd288);
        check_val("mid_rst_moving", 32'(moving), 32'd0);
        check_val("mid_rst_dir_r", 32'(dir_r), 32'd0);
        check_val("mid_rst_at_right", 32'(at_right), 32'd0);
        @(negedge clk);
        tick  = 1'b0;
        btn_r = 1'b0;
        rst_n = 1'b1;
        do_tick(1'b0, 1'b1);
        check_pos("post_rst", 290, 1'b1);
`ifdef PADDLE_ACCEL_EN
        check_val("post_rst_hold", 32'(dut.hold_cnt_q), 32'd1);
`endif

        // Right clamp from 570
        do_tick(1'b0, 1'b0);
        repeat (9) burst(1'b0, 1'b1, 15);
        burst(1'b0, 1'b1, 5);
        check_pos("to570", 570, 1'b0);
        do_tick(1'b0, 1'b1);
        check_pos("rc1", 572, 1'b1);
        do_tick(1'b0, 1'b1);
        check_pos("rc2", 574, 1'b1);
        do_tick(1'b0, 1'b1);
        check_pos("rc3", 576, 1'b1);
        check_val("rc3_at_right", 32'(at_right), 32'd1);
        do_tick(1'b0, 1'b1);
        check_pos("rc4", 576, 1'b0);
        check_val("rc4_at_right", 32'(at_right), 32'd1);
        check_val("rc4_dir_r", 32'(dir_r), 32'd1);

        // Left clamp from 6
        repeat (19) burst(1'b1, 1'b0, 15);
        check_pos("to6", 6, 1'b0);
        check_val("to6_at_right", 32'(at_right), 32'd0);
        do_tick(1'b1, 1'b0);
        check_pos("lc1", 4, 1'b1);
        do_tick(1'b1, 1'b0);
        check_pos("lc2", 2, 1'b1);
        check_val("lc2_at_left", 32'(at_left), 32'd0);
        do_tick(1'b1, 1'b0);
        check_pos("lc3", 0, 1'b1);
        check_val("lc3_at_left", 32'(at_left), 32'd1);
        do_tick(1'b1, 1'b0);
        check_pos("lc4", 0, 1'b0);
        check_val("lc4_at_left", 32'(at_left), 32'd1);
        check_val("lc4_dir_r", 32'(dir_r), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
